// File: rtl/serial_addsub_ctrl_pkg.sv
// Shared encodings for the bit-serial add/sub controller: FSM states and opcodes.
package serial_addsub_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_ctrl_if.sv
// Request/result bundle between a requester (master) and the serial add/sub engine (slave).
interface serial_addsub_ctrl_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;

  modport master (
    output start, op, a, b,
    input  busy, done, result, cout
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, cout
  );

endinterface

// File: rtl/serial_addsub_ctrl_fulladdsub_bit.sv
// One-bit full add/sub cell: two half add/sub stages whose generate/borrow terms are ORed.
module fulladdsub_bit
  import serial_addsub_ctrl_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic op,
  output logic s,
  output logic cout
);

  logic half_x;
  logic half_g;
  logic tail_g;

  // For subtract the minuend bit is inverted in each stage's borrow term.
  assign half_x = a ^ b;
  assign half_g = (op == OP_SUB) ? (~a & b) : (a & b);
  assign s      = half_x ^ cin;
  assign tail_g = (op == OP_SUB) ? (~half_x & cin) : (half_x & cin);
  assign cout   = half_g | tail_g;

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/sub controller: one bit per clock LSB first, carry/borrow rippled through a flag register.
module serial_addsub_ctrl
  import serial_addsub_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst,
  serial_addsub_ctrl_if.slave bus
);

  localparam int                 CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]      LAST_CNT = CW'(WIDTH - 1);

  state_t           state_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             op_reg;
  logic             flag_reg;
  logic [WIDTH-1:0] result_reg;
  logic             cout_reg;
  logic             busy_reg;
  logic             done_reg;

  logic             bit_s;
  logic             bit_c;

  fulladdsub_bit u_bit (
    .a   (a_reg[0]),
    .b   (b_reg[0]),
    .cin (flag_reg),
    .op  (op_reg),
    .s   (bit_s),
    .cout(bit_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      op_reg     <= OP_ADD;
      flag_reg   <= 1'b0;
      result_reg <= '0;
      cout_reg   <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          if (bus.start) begin
            a_reg     <= bus.a;
            b_reg     <= bus.b;
            op_reg    <= bus.op;
            flag_reg  <= 1'b0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= RUN;
          end else begin
            state_reg <= IDLE;
          end
        end
        RUN: begin
          // Operands shift right so the active bit is always at position 0.
          a_reg      <= a_reg >> 1;
          b_reg      <= b_reg >> 1;
          result_reg <= {bit_s, result_reg[WIDTH-1:1]};
          flag_reg   <= bit_c;
          cnt_reg    <= cnt_reg + 1'b1;
          if (cnt_reg == LAST_CNT) begin
            cout_reg  <= bit_c;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = busy_reg;
  assign bus.done   = done_reg;
  assign bus.result = result_reg;
  assign bus.cout   = cout_reg;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Randomized and directed bench for serial_addsub_ctrl against an arithmetic reference model.
module tb_serial_addsub_ctrl;

  localparam int WIDTH = 8;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  serial_addsub_ctrl_if #(.WIDTH(WIDTH)) bus ();

  serial_addsub_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference: {cout, result} from plain unsigned arithmetic.
  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] xa, xb, input logic xop);
    logic [WIDTH-1:0] diff;
    if (!xop) return {1'b0, xa} + {1'b0, xb};
    diff = xa - xb;
    return {(xa < xb), diff};
  endfunction

  // Called at a negedge while the engine is idle or in its done cycle.
  task automatic start_op(input logic [WIDTH-1:0] xa, xb, input logic xop);
    bus.start = 1'b1;
    bus.a     = xa;
    bus.b     = xb;
    bus.op    = xop;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = WIDTH'($urandom);
    bus.b     = WIDTH'($urandom);
    bus.op    = 1'($urandom);
  endtask

  // Follows an accepted op through RUN; optionally pokes start at RUN cycle 'poke'.
  // Returns at the negedge of the done cycle.
  task automatic follow_op(input logic [WIDTH-1:0] xa, xb, input logic xop, input int poke);
    logic [WIDTH:0] exp_v;
    exp_v = model(xa, xb, xop);
    for (int i = 1; i <= WIDTH; i++) begin
      chk("busy_run", 32'(bus.busy), 32'd1);
      chk("done_run", 32'(bus.done), 32'd0);
      bus.start = (i == poke);
      if (i == poke) begin
        bus.a  = 8'h01;
        bus.b  = 8'h01;
        bus.op = 1'b0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    chk("done_pulse", 32'(bus.done), 32'd1);
    chk("busy_done", 32'(bus.busy), 32'd0);
    chk("result", 32'(bus.result), 32'(exp_v[WIDTH-1:0]));
    chk("cout", 32'(bus.cout), 32'(exp_v[WIDTH]));
    $display("op=%s a=%02h b=%02h -> result=%02h cout=%0b (exp %02h/%0b)",
             xop ? "sub" : "add", xa, xb, bus.result, bus.cout, exp_v[WIDTH-1:0], exp_v[WIDTH]);
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb, pa, pb;
    logic             rop, pop, chain;
    logic [WIDTH:0]   prev;

    n_checks  = 0;
    n_pass    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.op    = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_result", 32'(bus.result), 32'd0);
    chk("rst_cout", 32'(bus.cout), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_done", 32'(bus.done), 32'd0);
    end

    // Directed adds and subtracts.
    start_op(8'h5A, 8'h3C, 1'b0); follow_op(8'h5A, 8'h3C, 1'b0, 0);
    @(negedge clk);
    chk("done_one_cycle", 32'(bus.done), 32'd0);
    chk("result_held", 32'(bus.result), 32'h96);
    start_op(8'hFF, 8'h01, 1'b0); follow_op(8'hFF, 8'h01, 1'b0, 0);
    @(negedge clk);
    start_op(8'h10, 8'h20, 1'b1); follow_op(8'h10, 8'h20, 1'b1, 0);
    @(negedge clk);
    start_op(8'h20, 8'h20, 1'b1); follow_op(8'h20, 8'h20, 1'b1, 0);
    @(negedge clk);

    // Start while busy is ignored: a single done with the original result.
    start_op(8'h5A, 8'h3C, 1'b0); follow_op(8'h5A, 8'h3C, 1'b0, 3);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("no_second_done", 32'(bus.done), 32'd0);
      chk("no_restart", 32'(bus.busy), 32'd0);
    end
    chk("result_after_ignore", 32'(bus.result), 32'h96);

    // Back-to-back: new start presented in the done cycle.
    start_op(8'h5A, 8'h3C, 1'b0); follow_op(8'h5A, 8'h3C, 1'b0, 0);
    start_op(8'h10, 8'h20, 1'b1); follow_op(8'h10, 8'h20, 1'b1, 0);
    @(negedge clk);

    // Reset in the middle of RUN.
    start_op(8'h5A, 8'h3C, 1'b0);
    repeat (3) @(negedge clk);
    chk("busy_before_abort", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_result", 32'(bus.result), 32'd0);
    chk("abort_cout", 32'(bus.cout), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(bus.done), 32'd0);
    end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("post_abort_no_done", 32'(bus.done), 32'd0);
    end
    start_op(8'h0F, 8'h01, 1'b0); follow_op(8'h0F, 8'h01, 1'b0, 0);

    // Random ops, randomly chained back-to-back or separated by idle cycles.
    pa   = 8'h0F;
    pb   = 8'h01;
    pop  = 1'b0;
    for (int n = 0; n < 30; n++) begin
      ra    = WIDTH'($urandom);
      rb    = WIDTH'($urandom);
      rop   = 1'($urandom);
      chain = 1'($urandom);
      if (n % 5 == 0) rb = ra;
      if (!chain) begin
        prev = model(pa, pb, pop);
        repeat (1 + $urandom_range(0, 3)) begin
          @(negedge clk);
          chk("rand_idle_done", 32'(bus.done), 32'd0);
        end
        chk("rand_held", 32'(bus.result), 32'(prev[WIDTH-1:0]));
      end
      start_op(ra, rb, rop);
      follow_op(ra, rb, rop, 0);
      pa  = ra;
      pb  = rb;
      pop = rop;
    end
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_addsub_ctrl.md
# serial_addsub_ctrl

Bit-serial adder/subtractor controller for the team's 1-bit half add/sub datapath. It accepts two WIDTH-bit operands and an opcode on a start handshake. It then sequences one full add/sub bit step per clock, LSB first, and rippling carry/borrow through a flag register. It reports a WIDTH-bit result plus carry/borrow-out with a one-cycle done pulse. It serves as the arithmetic engine for narrow, area-constrained datapaths in the same design.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE or DONE
- op  input  1  0 = add (a+b), 1 = subtract (a−b)
- a  input  WIDTH  operand A, captured on accepted start
- b  input  WIDTH  operand B, captured on accepted start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse: result/cout valid
- result  output  WIDTH  sum or difference, held until next accepted start
- cout  output  1  carry-out (add) or borrow-out (sub), held with result

## Operation
- Reset, asynchronous, active-high: state=IDLE. busy=0, done=0, result=0, cout=0, bit counter=0, flag=0, operand registers=0.
- FSM states are IDLE, RUN and DONE.
  - IDLE: on start=1, latch a, b and op. Clear the carry/borrow flag and counter. Go to RUN.
  - RUN: each cycle processes bit i=counter.
    - add: s = a_i^b_i^c. c' = a_i&b_i | c&(a_i^b_i).
    - sub: d = a_i^b_i^w. w' = ~a_i&b_i | ~(a_i^b_i)&w.
    - Shift s/d into result MSB side (right-shift register), so after WIDTH steps bit 0 sits at result[0].
    - Update the flag. Increment the counter.
    - When counter == WIDTH−1, go to DONE on that edge; cout takes the final flag.
  - DONE: done=1 for exactly this cycle. Next edge: start=1 goes to RUN (back-to-back accept, same as IDLE); otherwise go to IDLE.
- start in RUN is ignored; operands are not re-latched.
- Changes on a/b/op after acceptance have no effect.
- Results are modulo 2^WIDTH. cout=1 on unsigned overflow (add) or when a<b unsigned (sub).
- result bits are undefined-order during RUN. Only the value at done is specified; it is held through IDLE.

## Timing
- Start accepted on edge k. busy=1 in cycles k+1 … k+WIDTH. done=1 in cycle k+WIDTH+1 (after edge k+WIDTH).
- Latency from start to done is WIDTH+1 cycles. Throughput is one operation per WIDTH+1 cycles with back-to-back start.
- busy and done are never high together.
- rst asserted mid-RUN aborts immediately: all outputs go to reset values asynchronously, with no done pulse. The first start after rst deasserts is accepted normally.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package/header holds:
  - state encodings: IDLE=2'd0, RUN=2'd1, DONE=2'd2
  - opcode constants: OP_ADD=1'b0, OP_SUB=1'b1
- One sub-module, fulladdsub_bit: a 1-bit full add/sub cell built from two half add/sub stages plus the flag-combine OR.
  - Inputs: a, b, cin, op.
  - Outputs: s, cout.
  - Purely combinational; instantiated once.
- The controller holds the FSM, the counter ($clog2(WIDTH) bits), operand shift registers, the flag register and the result register.

## Test plan
All scenarios use WIDTH=8.
- Reset then idle: after rst, busy=0, done=0, result=0x00, cout=0, with no done pulse over 20 cycles.
- Add: a=0x5A, b=0x3C, op=0, start pulse. Expect busy for 8 cycles, then done in cycle 9 with result=0x96, cout=0. Also a=0xFF, b=0x01 gives result=0x00, cout=1.
- Subtract: a=0x10, b=0x20, op=1 gives result=0xF0, cout=1. Also a=0x20, b=0x20 gives result=0x00, cout=0.
- Start while busy: issue start with a=0x01, b=0x01 at cycle 3 of a running 0x5A+0x3C. It is ignored; a single done arrives with 0x96 and there is no second done.
- Back-to-back: hold start=1 with operands changed in the DONE cycle. The second op begins immediately, done pulses exactly 9 cycles apart, and each result is correct.
- Reset mid-operation: assert rst at RUN cycle 4. Outputs clear immediately and no done pulse occurs. After release, start a=0x0F, b=0x01 (add) gives result=0x10, cout=0.
